fetch_queue: RTL and testbench

- Parametrised multi-lane instruction fetch queue between instruction memory and the decode stages of the superscalar datapath.
- Generalises the fixed two-lane fetch (instr_1/instr_2, PC_1/PC_2) to WIDTH lanes. Adds DEPTH-entry buffering to absorb decode stalls, partial per-cycle consumption and a flush for redirects.
- Circular buffer: up to WIDTH {instr, pc} pairs enqueued per cycle; the WIDTH oldest entries are presented first-word-fall-through to decode.

---
 rtl/fetch_queue.sv | 127 ++++++++++++
 tb/tb_fetch_queue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: multi-lane instruction fetch buffer between instruction memory
// and decode. Up to WIDTH {instr, pc} pairs are accepted per cycle into a
// DEPTH-entry circular buffer. The WIDTH oldest entries are presented
// first-word-fall-through to decode.
//
// Handshake: fq_o_ready depends only on the registered occupancy. When it is
// high, a push of the leading valid lanes is accepted at the clock edge. Decode
// consumes 0..WIDTH head entries per cycle via fq_i_pop_cnt. An output lane is
// meaningful only while its fq_o_valid bit is set. A push while not ready, or a
// pop of more entries than are held, latches the sticky fq_o_ovf flag. That flag
// clears only on reset. Flush empties the queue. Any push or pop issued in the
// same cycle as a flush is discarded and does not set fq_o_ovf.
module fetch_queue #(
  parameter int IWIDTH   = 32,
  parameter int PC_WIDTH = 32,
  parameter int WIDTH    = 2,
  parameter int DEPTH    = 8
) (
  input  logic                          fq_clk,
  input  logic                          fq_rst,
  input  logic [WIDTH-1:0]              fq_i_valid,
  input  logic [WIDTH*IWIDTH-1:0]       fq_i_instr,
  input  logic [WIDTH*PC_WIDTH-1:0]     fq_i_pc,
  output logic                          fq_o_ready,
  input  logic [$clog2(WIDTH+1)-1:0]    fq_i_pop_cnt,
  input  logic                          fq_i_flush,
  output logic [WIDTH-1:0]              fq_o_valid,
  output logic [WIDTH*IWIDTH-1:0]       fq_o_instr,
  output logic [WIDTH*PC_WIDTH-1:0]     fq_o_pc,
  output logic [$clog2(DEPTH+1)-1:0]    fq_o_count,
  output logic                          fq_o_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int QW = $clog2(WIDTH+1);

  logic [IWIDTH-1:0]   instr_mem [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem    [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          ovf;

  logic [QW-1:0] push_cnt;
  logic [QW-1:0] push_eff;
  logic          do_push;
  logic          push_ovf;
  logic [CW-1:0] pop_req;
  logic [CW-1:0] pop_q;
  logic          pop_ovf;
  logic          run;

  // Push count is the run of consecutive valid lanes starting at lane 0.
  // Lanes after the first gap are ignored.
  always_comb begin
    push_cnt = '0;
    run      = 1'b1;
    for (int k = 0; k < WIDTH; k++) begin
      if (run && fq_i_valid[k]) begin
        push_cnt = push_cnt + QW'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  // Ready comes from registered occupancy only, so there is no path from
  // pop_cnt or flush to it.
  assign fq_o_ready = (count <= CW'(DEPTH - WIDTH));

  // Resolve the push and pop actually performed this cycle, and any overflow.
  always_comb begin
    do_push  = fq_o_ready && (push_cnt != '0);
    push_ovf = !fq_o_ready && (push_cnt != '0);
    push_eff = do_push ? push_cnt : '0;
    pop_req  = CW'(fq_i_pop_cnt);
    pop_ovf  = (pop_req > count);
    pop_q    = pop_ovf ? count : pop_req;
  end

  // Pointer, occupancy and sticky overflow state.
  always_ff @(posedge fq_clk) begin
    if (fq_rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (fq_i_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_q);
      tail  <= tail + PW'(push_eff);
      count <= count + CW'(push_eff) - pop_q;
      ovf   <= ovf | push_ovf | pop_ovf;
    end
  end

  // Storage write. Contents need no reset because validity is tracked by count.
  always_ff @(posedge fq_clk) begin
    for (int k = 0; k < WIDTH; k++) begin
      if (!fq_rst && !fq_i_flush && do_push && (k < int'(push_cnt))) begin
        instr_mem[tail + PW'(k)] <= fq_i_instr[k*IWIDTH +: IWIDTH];
        pc_mem[tail + PW'(k)]    <= fq_i_pc[k*PC_WIDTH +: PC_WIDTH];
      end
    end
  end

  // Fall-through read: lane k shows the entry k places behind head.
  always_comb begin
    fq_o_valid = '0;
    fq_o_instr = '0;
    fq_o_pc    = '0;
    for (int k = 0; k < WIDTH; k++) begin
      fq_o_valid[k]                     = (count > CW'(k));
      fq_o_instr[k*IWIDTH +: IWIDTH]    = instr_mem[head + PW'(k)];
      fq_o_pc[k*PC_WIDTH +: PC_WIDTH]   = pc_mem[head + PW'(k)];
    end
  end

  assign fq_o_count = count;
  assign fq_o_ovf   = ovf;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue with WIDTH=2, DEPTH=8 and 32-bit instr/pc.
// A directed vector table covers the main sequences and their corner cases.
// A wrap-around sequence follows, then a randomized run. Every cycle is also
// checked against a queue-based reference model.
module tb_fetch_queue;

  localparam int IW = 32;
  localparam int PW = 32;
  localparam int W  = 2;
  localparam int D  = 8;

  logic                 fq_clk = 1'b0;
  logic                 fq_rst;
  logic [W-1:0]         fq_i_valid;
  logic [W*IW-1:0]      fq_i_instr;
  logic [W*PW-1:0]      fq_i_pc;
  logic                 fq_o_ready;
  logic [1:0]           fq_i_pop_cnt;
  logic                 fq_i_flush;
  logic [W-1:0]         fq_o_valid;
  logic [W*IW-1:0]      fq_o_instr;
  logic [W*PW-1:0]      fq_o_pc;
  logic [3:0]           fq_o_count;
  logic                 fq_o_ovf;

  fetch_queue #(.IWIDTH(IW), .PC_WIDTH(PW), .WIDTH(W), .DEPTH(D)) dut (
    .fq_clk(fq_clk), .fq_rst(fq_rst),
    .fq_i_valid(fq_i_valid), .fq_i_instr(fq_i_instr), .fq_i_pc(fq_i_pc),
    .fq_o_ready(fq_o_ready), .fq_i_pop_cnt(fq_i_pop_cnt), .fq_i_flush(fq_i_flush),
    .fq_o_valid(fq_o_valid), .fq_o_instr(fq_o_instr), .fq_o_pc(fq_o_pc),
    .fq_o_count(fq_o_count), .fq_o_ovf(fq_o_ovf)
  );

  // Clock.
  always #5 fq_clk = ~fq_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: each queue entry is {instr, pc}.
  logic [63:0] mq[$];
  bit          m_ovf = 1'b0;

  typedef struct {
    logic        rst;
    logic [1:0]  valid;
    logic [31:0] i0, i1, p0, p1;
    logic [1:0]  pop;
    logic        flush;
    int          e_count;
    logic [1:0]  e_valid;
    logic        e_ready;
    logic        e_ovf;
    logic [31:0] e_pc0;
  } vec_t;

  vec_t tbl[21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t row(logic rst, logic [1:0] valid, logic [31:0] p0, logic [1:0] pop,
                               logic flush, int ec, logic [1:0] ev, logic er, logic eo,
                               logic [31:0] epc);
    vec_t v;
    v.rst = rst; v.valid = valid; v.p0 = p0; v.p1 = p0 + 32'd4;
    v.i0 = p0 + 32'h1000; v.i1 = p0 + 32'h1004; v.pop = pop; v.flush = flush;
    v.e_count = ec; v.e_valid = ev; v.e_ready = er; v.e_ovf = eo; v.e_pc0 = epc;
    return v;
  endfunction

  // Advance the model by one edge using the pre-edge model state.
  task automatic model_step(input logic rst, input logic [1:0] valid, input logic [31:0] i0,
                            input logic [31:0] i1, input logic [31:0] p0, input logic [31:0] p1,
                            input logic [1:0] pop, input logic flush);
    int p, q;
    bit rdy;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (flush) begin
      mq.delete();
    end else begin
      p   = valid[0] ? (valid[1] ? 2 : 1) : 0;
      rdy = (D - mq.size()) >= W;
      if (int'(pop) > mq.size()) m_ovf = 1'b1;
      q = (int'(pop) > mq.size()) ? mq.size() : int'(pop);
      repeat (q) void'(mq.pop_front());
      if (p > 0) begin
        if (rdy) begin
          mq.push_back({i0, p0});
          if (p == 2) mq.push_back({i1, p1});
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  // Compare all DUT outputs with the model.
  task automatic check_model();
    int sz;
    logic [63:0] e;
    sz = mq.size();
    check("count", 64'(fq_o_count), 64'(sz));
    check("valid", 64'(fq_o_valid), {62'd0, sz > 1, sz > 0});
    check("ready", 64'(fq_o_ready), 64'((D - sz) >= W));
    check("ovf", 64'(fq_o_ovf), 64'(m_ovf));
    for (int k = 0; k < W; k++) begin
      if (k < sz) begin
        e = mq[k];
        check("lane_instr", 64'(fq_o_instr[k*IW +: IW]), 64'(e[63:32]));
        check("lane_pc", 64'(fq_o_pc[k*PW +: PW]), 64'(e[31:0]));
      end
    end
  endtask

  // Driver: apply one cycle of inputs, advance the model, and check outputs
  // 1 time unit after the edge.
  task automatic step(input logic rst, input logic [1:0] valid, input logic [31:0] i0,
                      input logic [31:0] i1, input logic [31:0] p0, input logic [31:0] p1,
                      input logic [1:0] pop, input logic flush);
    fq_rst       = rst;
    fq_i_valid   = valid;
    fq_i_instr   = {i1, i0};
    fq_i_pc      = {p1, p0};
    fq_i_pop_cnt = pop;
    fq_i_flush   = flush;
    @(posedge fq_clk);
    model_step(rst, valid, i0, i1, p0, p1, pop, flush);
    #1;
    check_model();
  endtask

  initial begin
    logic [31:0] ra, rb, rc, rd;
    logic [1:0]  rv, rp;
    logic        rf, rr;

    fq_rst = 1'b1; fq_i_valid = '0; fq_i_instr = '0; fq_i_pc = '0;
    fq_i_pop_cnt = '0; fq_i_flush = 1'b0;

    //          rst valid p0      pop flush cnt valid rdy ovf pc0
    tbl[0]  = row(1, 2'b00, 32'd0,   0, 0, 0, 2'b00, 1, 0, 32'd0);
    tbl[1]  = row(0, 2'b00, 32'd0,   0, 0, 0, 2'b00, 1, 0, 32'd0);
    tbl[2]  = row(0, 2'b11, 32'd0,   0, 0, 2, 2'b11, 1, 0, 32'd0);
    tbl[2].i0 = 32'h20080005; tbl[2].i1 = 32'h20090007;
    tbl[3]  = row(0, 2'b00, 32'd0,   0, 0, 2, 2'b11, 1, 0, 32'd0);
    tbl[4]  = row(0, 2'b11, 32'd8,   0, 0, 4, 2'b11, 1, 0, 32'd0);
    tbl[5]  = row(0, 2'b11, 32'd16,  0, 0, 6, 2'b11, 1, 0, 32'd0);
    tbl[6]  = row(0, 2'b11, 32'd24,  0, 0, 8, 2'b11, 0, 0, 32'd0);
    tbl[7]  = row(0, 2'b11, 32'd32,  0, 0, 8, 2'b11, 0, 1, 32'd0);
    tbl[8]  = row(0, 2'b00, 32'd0,   1, 0, 7, 2'b11, 0, 1, 32'd4);
    tbl[9]  = row(0, 2'b00, 32'd0,   1, 0, 6, 2'b11, 1, 1, 32'd8);
    tbl[10] = row(0, 2'b00, 32'd0,   2, 0, 4, 2'b11, 1, 1, 32'd16);
    tbl[11] = row(0, 2'b00, 32'd0,   2, 0, 2, 2'b11, 1, 1, 32'd24);
    tbl[12] = row(0, 2'b00, 32'd0,   2, 0, 0, 2'b00, 1, 1, 32'd0);
    tbl[13] = row(0, 2'b11, 32'd100, 0, 0, 2, 2'b11, 1, 1, 32'd100);
    tbl[14] = row(0, 2'b11, 32'd108, 1, 1, 0, 2'b00, 1, 1, 32'd0);
    tbl[15] = row(0, 2'b11, 32'd40,  0, 0, 2, 2'b11, 1, 1, 32'd40);
    tbl[16] = row(0, 2'b10, 32'd48,  0, 0, 2, 2'b11, 1, 1, 32'd40);
    tbl[17] = row(0, 2'b00, 32'd0,   2, 0, 0, 2'b00, 1, 1, 32'd0);
    tbl[18] = row(1, 2'b00, 32'd0,   0, 0, 0, 2'b00, 1, 0, 32'd0);
    tbl[19] = row(0, 2'b01, 32'd60,  0, 0, 1, 2'b01, 1, 0, 32'd60);
    tbl[20] = row(0, 2'b00, 32'd0,   2, 0, 0, 2'b00, 1, 1, 32'd0);

    // Directed table: explicit expectations plus the model check.
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].rst, tbl[i].valid, tbl[i].i0, tbl[i].i1, tbl[i].p0, tbl[i].p1,
           tbl[i].pop, tbl[i].flush);
      check("tbl_count", 64'(fq_o_count), 64'(tbl[i].e_count));
      check("tbl_valid", 64'(fq_o_valid), 64'(tbl[i].e_valid));
      check("tbl_ready", 64'(fq_o_ready), 64'(tbl[i].e_ready));
      check("tbl_ovf", 64'(fq_o_ovf), 64'(tbl[i].e_ovf));
      if (tbl[i].e_count > 0) check("tbl_pc0", 64'(fq_o_pc[31:0]), 64'(tbl[i].e_pc0));
    end
    check("tbl2_instr1", 64'(tbl[2].i1), 64'h20090007);

    // Wrap-around: steady push 2 / pop 2 across the slot 7 to 0 boundary.
    step(1, 2'b00, 0, 0, 0, 0, 0, 0);
    step(0, 2'b11, 32'h1000, 32'h1004, 32'd0, 32'd4, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step(0, 2'b11, 32'h1000 + 32'(8*i), 32'h1004 + 32'(8*i), 32'(8*i), 32'(8*i+4), 2, 0);
      check("wrap_pc0", 64'(fq_o_pc[31:0]), 64'(8*i));
      check("wrap_pc1", 64'(fq_o_pc[63:32]), 64'(8*i+4));
      check("wrap_count", 64'(fq_o_count), 64'd2);
      check("wrap_ovf", 64'(fq_o_ovf), 64'd0);
    end

    // Randomized run checked against the model.
    step(1, 2'b00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      rv = 2'($urandom_range(0, 3));
      rp = 2'($urandom_range(0, 2));
      rf = ($urandom_range(0, 15) == 0);
      rr = ($urandom_range(0, 99) == 0);
      ra = $urandom; rb = $urandom; rc = $urandom; rd = $urandom;
      step(rr, rv, ra, rb, rc, rd, rp, rf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
